// File: rtl/sequenciador_jogadas_pkg.sv
// Shared definitions for the memory-game control unit: state encodings,
// debug display codes and the default per-play timeout.
package sequenciador_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  localparam int TIMEOUT_CICLOS_PADRAO = 3000;

  // The HEX5 display shows the raw state encoding.
  function automatic logic [3:0] db_codigo(estado_t e);
    return 4'(e);
  endfunction

endpackage

// File: rtl/sequenciador_jogadas_if.sv
// Control/status bundle between the memory-game datapath (master) and the
// sequencer (slave).
interface sequenciador_jogadas_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, igual, fimC,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou,
           db_timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual, fimC,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou,
           db_timeout, db_estado
  );
endinterface

// File: rtl/sequenciador_jogadas_contador_timeout.sv
// Per-play timeout counter: cleared by zera, counts while conta, saturates at
// TIMEOUT_CICLOS-1 and flags that value on fim.
module contador_timeout
  import sequenciador_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = $clog2(TIMEOUT_CICLOS);
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] contagem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta && contagem != ULTIMO) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/sequenciador_jogadas.sv
// Moore control unit for one round of the memory game: clear, wait for each
// play, register, compare, advance; ends in hit, miss or timeout.
module sequenciador_jogadas
  import sequenciador_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic                   clock,
  input  logic                   reset,
  sequenciador_jogadas_if.slave  bus
);

  estado_t estado;
  estado_t proximo;
  logic    fim_timeout;
  logic    zera_timeout;
  logic    conta_timeout;

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timeout),
    .conta (conta_timeout),
    .fim   (fim_timeout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:     if (bus.iniciar) proximo = PREPARA;
      PREPARA:     proximo = ESPERA;
      ESPERA: begin
        // A play arriving on the last allowed cycle beats the timeout.
        if (bus.jogada)       proximo = REGISTRA;
        else if (fim_timeout) proximo = FIM_TIMEOUT;
      end
      REGISTRA:    proximo = COMPARA;
      COMPARA: begin
        if (!bus.igual)     proximo = FIM_ERRO;
        else if (bus.fimC)  proximo = FIM_ACERTO;
        else                proximo = PROXIMO;
      end
      PROXIMO:     proximo = ESPERA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT: if (bus.iniciar) proximo = PREPARA;
      default:     proximo = INICIAL;
    endcase
  end

  // Outputs decode from the state register alone.
  always_comb begin
    bus.zeraC      = 1'b0;
    bus.contaC     = 1'b0;
    bus.zeraR      = 1'b0;
    bus.registraR  = 1'b0;
    bus.pronto     = 1'b0;
    bus.acertou    = 1'b0;
    bus.errou      = 1'b0;
    bus.db_timeout = 1'b0;
    case (estado)
      PREPARA: begin
        bus.zeraC = 1'b1;
        bus.zeraR = 1'b1;
      end
      REGISTRA:   bus.registraR = 1'b1;
      PROXIMO:    bus.contaC    = 1'b1;
      FIM_ACERTO: begin
        bus.pronto  = 1'b1;
        bus.acertou = 1'b1;
      end
      FIM_ERRO: begin
        bus.pronto = 1'b1;
        bus.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        bus.pronto     = 1'b1;
        bus.errou      = 1'b1;
        bus.db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.db_estado   = db_codigo(estado);
  assign zera_timeout    = (estado == PREPARA) || (estado == PROXIMO);
  assign conta_timeout   = (estado == ESPERA);

endmodule

// File: tb/tb_sequenciador_jogadas.sv
// Self-checking bench: rounds are described as plays (wait, hit/miss/timeout)
// and expanded into an expected per-cycle state trace with random don't-cares.
module tb_sequenciador_jogadas;

  localparam int T = 8;

  typedef struct {
    logic [3:0] code;
    logic       ini;
    logic       jog;
    logic       ig;
    logic       fc;
  } step_t;

  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   pulsos_conta;
  logic [3:0] cur;
  step_t q[$];

  always #5 clock = ~clock;

  sequenciador_jogadas_if bus();

  sequenciador_jogadas #(.TIMEOUT_CICLOS(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,db_timeout} per state.
  function automatic logic [7:0] outs_for(input logic [3:0] c);
    case (c)
      4'h1:    return 8'b1010_0000;
      4'h4:    return 8'b0001_0000;
      4'h6:    return 8'b0100_0000;
      4'hA:    return 8'b0000_1100;
      4'hE:    return 8'b0000_1010;
      4'hD:    return 8'b0000_1011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] outs_dut();
    return {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR,
            bus.pronto, bus.acertou, bus.errou, bus.db_timeout};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] c, input logic ini, input logic jog,
                      input logic ig, input logic fc);
    step_t s;
    s.code = c; s.ini = ini; s.jog = jog; s.ig = ig; s.fc = fc;
    q.push_back(s);
  endtask

  // One round from the current idle state; tmo/miss index the play that
  // times out / mismatches (-1 = none), fixed_wait < 0 draws waits randomly.
  task automatic gen_round(input int n, input int miss, input int tmo, input int fixed_wait);
    int w;
    logic g;
    push(cur, 1'b1, rb(), rb(), rb());
    push(4'h1, rb(), rb(), rb(), rb());
    for (int p = 0; p < n; p++) begin
      if (p == tmo) begin
        repeat (T) push(4'h2, rb(), 1'b0, rb(), rb());
        cur = 4'hD;
        break;
      end
      w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, T - 1));
      repeat (w) push(4'h2, rb(), 1'b0, rb(), rb());
      push(4'h2, rb(), 1'b1, rb(), rb());
      g = (p != miss);
      push(4'h4, rb(), rb(), rb(), rb());
      push(4'h5, rb(), rb(), g, (p == n - 1));
      if (!g) begin
        cur = 4'hE;
        break;
      end
      if (p == n - 1) begin
        cur = 4'hA;
        break;
      end
      push(4'h6, rb(), rb(), rb(), rb());
    end
    repeat (1 + $urandom_range(0, 3)) push(cur, 1'b0, rb(), rb(), rb());
  endtask

  task automatic run_queue(input string name);
    step_t s;
    int k = 0;
    pulsos_conta = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clock);
      check($sformatf("%s c%0d estado", name, k), {4'h0, bus.db_estado}, {4'h0, s.code});
      check($sformatf("%s c%0d saidas", name, k), outs_dut(), outs_for(s.code));
      if (bus.contaC) pulsos_conta++;
      bus.iniciar = s.ini;
      bus.jogada  = s.jog;
      bus.igual   = s.ig;
      bus.fimC    = s.fc;
      k++;
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.igual   = 1'b0;
    bus.fimC    = 1'b0;
    cur         = 4'h0;

    repeat (2) @(negedge clock);
    check("reset estado", {4'h0, bus.db_estado}, 8'h00);
    check("reset saidas", outs_dut(), 8'h00);
    reset = 1'b1;

    // Full correct round of 4 plays.
    gen_round(4, -1, -1, -1);
    run_queue("acerto4");
    check("acerto4 pulsos contaC", 8'(pulsos_conta), 8'd3);

    // Miss on the second play, then replay from FIM_ERRO.
    gen_round(4, 1, -1, -1);
    run_queue("erro2");
    check("erro2 pulsos contaC", 8'(pulsos_conta), 8'd1);

    // Timeout on the first play.
    gen_round(3, -1, 0, -1);
    run_queue("timeout0");

    // Plays on the last allowed cycle, then a timeout after PROXIMO.
    gen_round(3, -1, 2, T - 1);
    run_queue("limite");

    // Asynchronous reset mid-round with the timeout counter at 3.
    push(cur, 1'b1, 1'b0, 1'b0, 1'b0);
    push(4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) push(4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_queue("pre_reset");
    @(negedge clock);
    check("pre_reset espera", {4'h0, bus.db_estado}, 8'h02);
    #1 reset = 1'b0;
    #1;
    check("reset async estado", {4'h0, bus.db_estado}, 8'h00);
    check("reset async saidas", outs_dut(), 8'h00);
    @(negedge clock);
    reset = 1'b1;
    cur = 4'h0;
    repeat (4) push(4'h0, 1'b0, rb(), rb(), rb());
    run_queue("pos_reset");

    // After reset, a fresh timeout must take exactly T cycles again.
    gen_round(2, -1, 0, -1);
    run_queue("pos_reset_timeout");

    for (int r = 0; r < 25; r++) begin
      int n, sel, miss, tmo;
      n    = int'($urandom_range(1, 6));
      sel  = int'($urandom_range(0, 3));
      miss = (sel == 0) ? int'($urandom_range(0, n - 1)) : -1;
      tmo  = (sel == 1) ? int'($urandom_range(0, n - 1)) : -1;
      gen_round(n, miss, tmo, -1);
      run_queue($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
